// File: rtl/bcd_7seg_scan.sv
// Three-digit multiplexed seven-segment driver for the packed BCD output of b2bd_LOG.
// Provides leading-zero blanking, a dash for invalid digits, and a frame-latched shadow value.
module bcd_7seg_scan #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bdc,
    input  logic        blank,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        frm
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        UNITS    = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2
    } dig_t;

    dig_t          dig;
    dig_t          dig_nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          load;
    logic [11:0]   shd;
    logic [3:0]    n;
    logic          dblank;
    logic [6:0]    dec;
    logic [2:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          frm_pend;

    assign tick = (cnt == CMAX);
    assign load = tick && (dig == HUNDREDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            dig <= UNITS;
        end else begin
            dig <= dig_nxt;
        end
    end

    always_comb begin
        dig_nxt = dig;
        case (dig)
            UNITS:    if (tick) dig_nxt = TENS;
            TENS:     if (tick) dig_nxt = HUNDREDS;
            HUNDREDS: if (tick) dig_nxt = UNITS;
            default:  dig_nxt = UNITS;
        endcase
    end

    // The shadow value only changes at the HUNDREDS->UNITS boundary, so a frame never mixes results.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            shd <= 12'h000;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (load) begin
                shd <= bdc;
            end
        end
    end

    always_comb begin
        n      = shd[3:0];
        dblank = 1'b0;
        case (dig)
            UNITS: begin
                n      = shd[3:0];
                dblank = 1'b0;
            end
            TENS: begin
                n      = shd[7:4];
                dblank = (shd[11:8] == 4'd0) && (shd[7:4] == 4'd0);
            end
            HUNDREDS: begin
                n      = shd[11:8];
                dblank = (shd[11:8] == 4'd0);
            end
            default: begin
                n      = shd[3:0];
                dblank = 1'b0;
            end
        endcase
    end

    always_comb begin
        dec = 7'b0111111;
        case (n)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    end

    always_comb begin
        an_nxt  = 3'b111;
        seg_nxt = 7'b1111111;
        if (!blank && !dblank) begin
            seg_nxt = dec;
            case (dig)
                UNITS:    an_nxt = 3'b110;
                TENS:     an_nxt = 3'b101;
                HUNDREDS: an_nxt = 3'b011;
                default:  an_nxt = 3'b111;
            endcase
        end
    end

    // frm is delayed one extra stage so it coincides with the first displayed digit of the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            an       <= 3'b111;
            seg      <= 7'b1111111;
            frm_pend <= 1'b0;
            frm      <= 1'b0;
        end else begin
            an       <= an_nxt;
            seg      <= seg_nxt;
            frm_pend <= load;
            frm      <= frm_pend;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan: directed per-cycle expectations are queued by the stimulus
// process and popped by an independent monitor on every falling edge.
module tb_bcd_7seg_scan;

    localparam int DWELL = 4;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] SDSH = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [11:0] bdc;
    logic        blank;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        frm;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        logic       frm;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    bcd_7seg_scan #(.DWELL(DWELL)) dut (
        .clk   (clk),
        .rst   (rst),
        .bdc   (bdc),
        .blank (blank),
        .an    (an),
        .seg   (seg),
        .frm   (frm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the output expected after the next rising edge, then advance one cycle.
    task automatic push_exp(input logic [2:0] a, input logic [6:0] s, input logic f, input string tag);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.frm = f;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] a, input logic [6:0] s, input logic f,
                                  input int count, input string tag);
        for (int i = 0; i < count; i++) begin
            push_exp(a, s, (i == 0) ? f : 1'b0, tag);
        end
    endtask

    task automatic check_output(input exp_t e);
        compared++;
        if (an !== e.an || seg !== e.seg || frm !== e.frm) begin
            mismatched++;
            $display("[TB] FAIL %s: got an=%b seg=%b frm=%b, expected an=%b seg=%b frm=%b",
                     e.tag, an, seg, frm, e.an, e.seg, e.frm);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            check_output(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        blank = 1'b0;
        bdc   = 12'h000;

        apply_stimulus(3'b111, SOFF, 1'b0, 3, "reset_hold");
        rst = 1'b0;
        bdc = 12'h255;

        // Frame 0 shows the reset shadow value 0.
        apply_stimulus(3'b110, S0,   1'b0, DWELL, "post_reset_units0");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "post_reset_tens_blank");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "post_reset_hund_blank");

        apply_stimulus(3'b110, S5, 1'b1, DWELL, "f1_255_units");
        apply_stimulus(3'b101, S5, 1'b0, DWELL, "f1_255_tens");
        apply_stimulus(3'b011, S2, 1'b0, DWELL, "f1_255_hund");
        bdc = 12'h007;
        apply_stimulus(3'b110, S5, 1'b1, DWELL, "f2_255_units");
        apply_stimulus(3'b101, S5, 1'b0, DWELL, "f2_255_tens");
        apply_stimulus(3'b011, S2, 1'b0, DWELL, "f2_255_hund");
        bdc = 12'h100;
        apply_stimulus(3'b110, S7,   1'b1, DWELL, "f3_007_units");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "f3_007_tens_blank");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "f3_007_hund_blank");
        bdc = 12'h0A3;
        apply_stimulus(3'b110, S0, 1'b1, DWELL, "f4_100_units0");
        apply_stimulus(3'b101, S0, 1'b0, DWELL, "f4_100_tens0");
        apply_stimulus(3'b011, S1, 1'b0, DWELL, "f4_100_hund1");
        bdc = 12'h123;
        apply_stimulus(3'b110, S3,   1'b1, DWELL, "f5_0a3_units");
        apply_stimulus(3'b101, SDSH, 1'b0, DWELL, "f5_0a3_tens_dash");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "f5_0a3_hund_blank");

        // Input changes mid-frame; the current frame keeps showing 123.
        apply_stimulus(3'b110, S3, 1'b1, DWELL, "f6_123_units");
        apply_stimulus(3'b101, S2, 1'b0, 2, "f6_123_tens_early");
        bdc = 12'h045;
        apply_stimulus(3'b101, S2, 1'b0, DWELL - 2, "f6_123_tens_late");
        apply_stimulus(3'b011, S1, 1'b0, DWELL, "f6_123_hund");
        apply_stimulus(3'b110, S5,   1'b1, DWELL, "f7_045_units");
        apply_stimulus(3'b101, S4,   1'b0, DWELL, "f7_045_tens");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "f7_045_hund_blank");

        // 20 blanked cycles; frm keeps pulsing at each frame start.
        blank = 1'b1;
        apply_stimulus(3'b111, SOFF, 1'b1, 3 * DWELL, "f8_blanked");
        apply_stimulus(3'b111, SOFF, 1'b1, 2 * DWELL, "f9_blanked");
        blank = 1'b0;
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "f9_hund_blank");

        apply_stimulus(3'b110, S5, 1'b1, DWELL, "f10_045_units");
        rst = 1'b1;
        apply_stimulus(3'b111, SOFF, 1'b0, 2, "midframe_reset");
        rst = 1'b0;
        apply_stimulus(3'b110, S0,   1'b0, DWELL, "restart_units0");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "restart_tens_blank");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "restart_hund_blank");
        apply_stimulus(3'b110, S5,   1'b1, DWELL, "restart_045_units");
        apply_stimulus(3'b101, S4,   1'b0, DWELL, "restart_045_tens");
        apply_stimulus(3'b111, SOFF, 1'b0, DWELL, "restart_045_hund_blank");

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
